// File: rtl/testeio_onchip_memory_dp.sv
// True-dual-port on-chip RAM with two Avalon-MM slaves, byte enables, 1- or 2-cycle read
// latency with readdatavalid, clock-enable stalls and an optional zero-fill sweep after reset.
module testeio_onchip_memory_dp #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 8,
    parameter int READ_LAT     = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,
    input  logic                  reset_req,
    input  logic                  freeze,
    input  logic [ADDR_W-1:0]     s1_address,
    input  logic                  s1_chipselect,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [DATA_W-1:0]     s1_writedata,
    input  logic [DATA_W/8-1:0]   s1_byteenable,
    output logic [DATA_W-1:0]     s1_readdata,
    output logic                  s1_readdatavalid,
    output logic                  s1_waitrequest,
    input  logic [ADDR_W-1:0]     s2_address,
    input  logic                  s2_chipselect,
    input  logic                  s2_read,
    input  logic                  s2_write,
    input  logic [DATA_W-1:0]     s2_writedata,
    input  logic [DATA_W/8-1:0]   s2_byteenable,
    output logic [DATA_W-1:0]     s2_readdata,
    output logic                  s2_readdatavalid,
    output logic                  s2_waitrequest
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {ST_CLEAR, ST_READY} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   clr_addr_reg, clr_addr_next;
    logic                clearing, ready;
    logic                en, acc_ok, clr_we;

    // Port 0 = s1, port 1 = s2; indexed so both ports share one generate body.
    logic [ADDR_W-1:0]          addr  [2];
    logic [DATA_W-1:0]          wdata [2];
    logic [NB-1:0]              be    [2];
    logic [1:0]                 cs, rd_req, wr_req;
    logic [1:0]                 rd_acc, wr_acc, we;
    logic [1:0][DATA_W-1:0]     rd_q;
    logic [1:0][DATA_W-1:0]     rdata;
    logic [1:0]                 rvalid;

    assign addr[0]  = s1_address;
    assign addr[1]  = s2_address;
    assign wdata[0] = s1_writedata;
    assign wdata[1] = s2_writedata;
    assign be[0]    = s1_byteenable;
    assign be[1]    = s2_byteenable;
    assign cs       = {s2_chipselect, s1_chipselect};
    assign rd_req   = {s2_read, s1_read};
    assign wr_req   = {s2_write, s1_write};

    assign en     = clken & ~reset_req;
    assign acc_ok = ready & en & ~reset;
    assign clr_we = clearing & en & ~reset;

    // A simultaneous read+write on one port is treated as a write only.
    assign wr_acc = {2{acc_ok}} & cs & wr_req;
    assign rd_acc = {2{acc_ok}} & cs & rd_req & ~wr_req;
    assign we     = wr_acc & {2{~freeze}};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;
            clr_addr_reg <= '0;
        end else if (en) begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        case (state_reg)
            ST_CLEAR: begin
                clr_addr_next = clr_addr_reg + 1'b1;
                if (clr_addr_reg == '1)
                    state_next = ST_READY;
            end
            default: state_next = ST_READY;
        endcase
    end

    // Output decode
    always_comb begin
        clearing = 1'b0;
        ready    = 1'b0;
        case (state_reg)
            ST_CLEAR: clearing = 1'b1;
            default:  ready    = 1'b1;
        endcase
    end

    assign s1_waitrequest = ~acc_ok;
    assign s2_waitrequest = ~acc_ok;

    // One byte-wide RAM per lane; s1 is written last so it wins a same-address collision.
    genvar gi, gp;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                if (clr_we) begin
                    mem[clr_addr_reg] <= '0;
                end else begin
                    if (we[1] && be[1][gi])
                        mem[addr[1]] <= wdata[1][gi*8 +: 8];
                    if (we[0] && be[0][gi])
                        mem[addr[0]] <= wdata[0][gi*8 +: 8];
                end
            end

            for (gp = 0; gp < 2; gp++) begin : g_rd
                logic [7:0] q_reg;
                // Loads only on an accepted read, so it returns pre-write data and holds otherwise.
                always_ff @(posedge clk) begin
                    if (reset)
                        q_reg <= '0;
                    else if (rd_acc[gp])
                        q_reg <= mem[addr[gp]];
                end
                assign rd_q[gp][gi*8 +: 8] = q_reg;
            end
        end

        for (gp = 0; gp < 2; gp++) begin : g_port
            logic v1_reg;

            always_ff @(posedge clk) begin
                if (reset)
                    v1_reg <= 1'b0;
                else if (en)
                    v1_reg <= rd_acc[gp];
            end

            if (READ_LAT == 2) begin : g_lat2
                logic              v2_reg;
                logic [DATA_W-1:0] d2_reg;

                always_ff @(posedge clk) begin
                    if (reset) begin
                        v2_reg <= 1'b0;
                        d2_reg <= '0;
                    end else if (en) begin
                        v2_reg <= v1_reg;
                        if (v1_reg)
                            d2_reg <= rd_q[gp];
                    end
                end
                // A stalled response stays pending and is presented again once en returns.
                assign rvalid[gp] = v2_reg & en;
                assign rdata[gp]  = d2_reg;
            end else begin : g_lat1
                assign rvalid[gp] = v1_reg & en;
                assign rdata[gp]  = rd_q[gp];
            end
        end
    endgenerate

    assign s1_readdata      = rdata[0];
    assign s2_readdata      = rdata[1];
    assign s1_readdatavalid = rvalid[0];
    assign s2_readdatavalid = rvalid[1];

endmodule

// File: tb/tb_testeio_onchip_memory_dp.sv
// Directed plus randomised check of the dual-port RAM against a reference memory model and
// per-port response queues that also carry the en-cycle at which each response is due.
module tb_testeio_onchip_memory_dp;
    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int LAT = 2;
    localparam int NB  = DW / 8;

    logic          clk = 1'b0;
    logic          reset, clken, reset_req, freeze;
    logic [AW-1:0] s1_address, s2_address;
    logic          s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
    logic [DW-1:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
    logic [NB-1:0] s1_byteenable, s2_byteenable;
    logic          s1_readdatavalid, s2_readdatavalid, s1_waitrequest, s2_waitrequest;

    testeio_onchip_memory_dp #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(LAT), .CLEAR_ON_RST(1)) dut (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req), .freeze(freeze),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
        .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
        .s1_waitrequest(s1_waitrequest),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_writedata(s2_writedata), .s2_byteenable(s2_byteenable),
        .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid),
        .s2_waitrequest(s2_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        q1[$], q2[$];
    logic [31:0] model [256];
    logic [31:0] last_v [2];
    int          ecount = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    bit          ready_tb = 0;
    bit          mon_on = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkb(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic void mwrite(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
        for (int k = 0; k < NB; k++)
            if (b[k]) model[a][k*8 +: 8] = d[k*8 +: 8];
    endfunction

    // en-cycle counter: advances on every edge where the DUT pipeline may move
    always @(posedge clk)
        if (clken && !reset_req && !reset) ecount <= ecount + 1;

    task automatic mon(input int p, input logic rdv, input logic [31:0] rd);
        exp_t e;
        if (rdv) begin
            if ((p == 1 ? q1.size() : q2.size()) == 0) begin
                checkb($sformatf("s%0d_unexpected_rdv", p), rdv, 1'b0);
            end else begin
                if (p == 1) e = q1.pop_front();
                else        e = q2.pop_front();
                check($sformatf("s%0d_readdata", p), rd, e.data);
                check($sformatf("s%0d_latency_ecycle", p), ecount, e.due);
                last_v[p-1] = e.data;
                $display("rsp s%0d data=0x%08h ecycle=%0d", p, rd, ecount);
            end
        end else if (clken && !reset_req) begin
            check($sformatf("s%0d_readdata_hold", p), rd, last_v[p-1]);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (!(clken && !reset_req)) begin
                checkb("s1_rdv_en_low", s1_readdatavalid, 1'b0);
                checkb("s2_rdv_en_low", s2_readdatavalid, 1'b0);
            end
            mon(1, s1_readdatavalid, s1_readdata);
            mon(2, s2_readdatavalid, s2_readdata);
        end
    end

    task automatic idle_bus();
        s1_chipselect = 0; s1_read = 0; s1_write = 0;
        s2_chipselect = 0; s2_read = 0; s2_write = 0;
    endtask

    // One bus cycle on both ports; expectations are queued before the model sees this cycle's writes.
    task automatic step(input logic r1, input logic w1, input logic [7:0] a1, input logic [31:0] d1,
                        input logic [3:0] b1, input logic r2, input logic w2, input logic [7:0] a2,
                        input logic [31:0] d2, input logic [3:0] b2);
        exp_t e;
        bit   acc;
        s1_chipselect = r1 | w1; s1_read = r1; s1_write = w1;
        s1_address = a1; s1_writedata = d1; s1_byteenable = b1;
        s2_chipselect = r2 | w2; s2_read = r2; s2_write = w2;
        s2_address = a2; s2_writedata = d2; s2_byteenable = b2;
        acc = clken && !reset_req && ready_tb;
        if (acc) begin
            e.due = ecount + LAT;
            if (r1 && !w1) begin e.data = model[a1]; q1.push_back(e); end
            if (r2 && !w2) begin e.data = model[a2]; q2.push_back(e); end
            if (!freeze) begin
                if (w2) mwrite(a2, d2, b2);
                if (w1) mwrite(a1, d1, b1);
            end
        end
        @(negedge clk);
        checkb("s1_waitrequest", s1_waitrequest, !acc);
        checkb("s2_waitrequest", s2_waitrequest, !acc);
        @(posedge clk);
        #1;
        idle_bus();
    endtask

    task automatic w1(input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
        step(0, 1, a, d, b, 0, 0, 8'h0, 32'h0, 4'h0);
    endtask
    task automatic r1(input logic [7:0] a);
        step(1, 0, a, 32'h0, 4'h0, 0, 0, 8'h0, 32'h0, 4'h0);
    endtask
    task automatic r2(input logic [7:0] a);
        step(0, 0, 8'h0, 32'h0, 4'h0, 1, 0, a, 32'h0, 4'h0);
    endtask
    task automatic drain();
        repeat (LAT + 3) step(0, 0, 8'h0, 32'h0, 4'h0, 0, 0, 8'h0, 32'h0, 4'h0);
    endtask

    task automatic pulse_reset();
        mon_on = 0; ready_tb = 0;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        last_v[0] = '0; last_v[1] = '0;
        for (int i = 0; i < 256; i++) model[i] = '0;
    endtask

    task automatic wait_clear(input string tag);
        int cnt = 0;
        while (cnt < 400) begin
            @(negedge clk);
            if (s1_waitrequest && s2_waitrequest) cnt++;
            else break;
        end
        check(tag, cnt, 256);
        @(posedge clk); #1;
        ready_tb = 1; mon_on = 1;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        reset = 1; clken = 1; reset_req = 0; freeze = 0;
        s1_address = 0; s1_writedata = 0; s1_byteenable = 0;
        s2_address = 0; s2_writedata = 0; s2_byteenable = 0;
        idle_bus();
        last_v[0] = '0; last_v[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_s1_readdata", s1_readdata, 32'h0);
        check("reset_s2_readdata", s2_readdata, 32'h0);
        checkb("reset_s1_rdv", s1_readdatavalid, 1'b0);
        checkb("reset_s1_waitrequest", s1_waitrequest, 1'b1);
        checkb("reset_s2_waitrequest", s2_waitrequest, 1'b1);
        reset = 0;
        for (int i = 0; i < 256; i++) model[i] = '0;
        wait_clear("clear_cycles_first");

        // Dirty memory, then reset, interrupt the sweep with a second reset, and expect a full restart
        w1(8'h00, 32'hDEADBEEF, 4'hF);
        w1(8'hFF, 32'hCAFEF00D, 4'hF);
        pulse_reset();
        repeat (100) @(posedge clk);
        #1;
        pulse_reset();
        wait_clear("clear_cycles_restart");
        r1(8'h00); r2(8'hFF); r1(8'h80);
        drain();

        // Byte-enable merge
        w1(8'hA0, 32'h11223344, 4'b1111);
        w1(8'hA0, 32'hFFFFFFFF, 4'b0101);
        r2(8'hA0);
        drain();
        check("model_be_merge", model[8'hA0], 32'h11FF33FF);

        // Back-to-back reads, distinct data so ordering is visible
        for (int i = 0; i < 8; i++) w1(8'(i), 32'hC0DE0000 + i, 4'hF);
        r1(8'h00); r1(8'h01); r1(8'h02);
        drain();

        // Cross-port read-during-write returns old data
        step(0, 1, 8'h10, 32'h5, 4'hF, 1, 0, 8'h10, 32'h0, 4'h0);
        r2(8'h10);
        // Same-port read+write: write only, no response
        step(1, 1, 8'h40, 32'h99, 4'hF, 0, 0, 8'h0, 32'h0, 4'h0);
        r1(8'h40);
        drain();

        // Dual write collision
        w1(8'h20, 32'h000000C3, 4'hF);
        step(0, 1, 8'h20, 32'hAAAAAAAA, 4'b1100, 0, 1, 8'h20, 32'h55555555, 4'b0110);
        r1(8'h20);
        drain();
        check("model_collision", model[8'h20], 32'hAAAA55C3);

        // Frozen write is acknowledged but dropped
        w1(8'h30, 32'h1234, 4'hF);
        freeze = 1;
        w1(8'h30, 32'h7, 4'hF);
        freeze = 0;
        r1(8'h30);
        drain();

        // reset_req and clken stalls in the middle of a read burst
        for (int i = 0; i < 10; i++) begin
            reset_req = (i == 2 || i == 3);
            clken     = !(i == 6);
            step(1, 0, 8'(i % 8), 32'h0, 4'h0, 1, 0, 8'(7 - (i % 8)), 32'h0, 4'h0);
        end
        reset_req = 0; clken = 1;
        drain();

        // Randomised traffic on a small address window to force collisions
        for (int i = 0; i < 300; i++) begin
            clken     = ($urandom_range(0, 7) != 0);
            reset_req = ($urandom_range(0, 15) == 0);
            freeze    = ($urandom_range(0, 9) == 0);
            step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 8'($urandom_range(0, 7)),
                 $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 8'($urandom_range(0, 7)),
                 $urandom, 4'($urandom_range(0, 15)));
        end
        clken = 1; reset_req = 0; freeze = 0;
        drain();

        check("s1_no_lost_responses", q1.size(), 0);
        check("s2_no_lost_responses", q2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
